// File: rtl/ate_block_scheduler.sv
// ---------------------------------------------------------------------------
// ate_block_scheduler
//
// Sequencer for the adaptive-threshold datapath. Each accepted pixel is
// steered into one half of a two-bank (ping-pong) pixel buffer. The other
// half is replayed to the binarizer at the same time. The block also
// generates the accumulator clear/enable, the threshold load, the buffer
// addresses and the edge-block flag for each block.
//
// Ports
//   clk, rst       clock; synchronous active-high reset (aborts a frame)
//   start          frame start pulse, honoured only while idle
//   type_sel       line width select (0: BLK_NARROW, 1: BLK_WIDE blocks);
//                  sampled on start. Named type_sel because "type" is a
//                  SystemVerilog keyword.
//   in_valid       upstream pixel valid
//   in_ready       upstream handshake; a transfer is in_valid & in_ready
//   out_ready      downstream binarizer accepts the emitted pixel
//   acc_clr        accumulator loads the current pixel (first of block)
//   acc_en         accumulator updates with the current pixel
//   wr_en          buffer write strobe
//   wr_bank        bank being filled
//   wr_addr        write offset within the bank
//   rd_bank        bank being replayed
//   rd_addr        read offset within the bank
//   thr_load       capture the threshold of the block just completed
//   emit_valid     rd_bank/rd_addr point at a valid pixel
//   emit_edge      emitted block is the first or last block of its line
//   emit_last      last pixel of the frame is being presented
//   busy           controller is not idle
//   done           one-cycle pulse once the frame has fully drained
// ---------------------------------------------------------------------------
module ate_block_scheduler #(
    parameter int PIX_PER_BLK = 64,
    parameter int BLK_NARROW  = 6,
    parameter int BLK_WIDE    = 66,
    parameter int LINES       = 4,
    localparam int PIX_W      = $clog2(PIX_PER_BLK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             type_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             wr_en,
    output logic             wr_bank,
    output logic [PIX_W-1:0] wr_addr,
    output logic             rd_bank,
    output logic [PIX_W-1:0] rd_addr,
    output logic             thr_load,
    output logic             emit_valid,
    output logic             emit_edge,
    output logic             emit_last,
    output logic             busy,
    output logic             done
);

    localparam int BLK_MAX = (BLK_WIDE > BLK_NARROW) ? BLK_WIDE : BLK_NARROW;
    localparam int BLK_W   = $clog2(BLK_MAX);
    localparam int LINE_W  = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [PIX_W-1:0]  PIX_M1    = PIX_W'(PIX_PER_BLK - 1);
    localparam logic [BLK_W-1:0]  NARROW_M1 = BLK_W'(BLK_NARROW - 1);
    localparam logic [BLK_W-1:0]  WIDE_M1   = BLK_W'(BLK_WIDE - 1);
    localparam logic [LINE_W-1:0] LINES_M1  = LINE_W'(LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;

    logic              type_q;
    logic [PIX_W-1:0]  in_pix_q,  out_pix_q;
    logic [BLK_W-1:0]  in_blk_q,  out_blk_q;
    logic [LINE_W-1:0] in_line_q, out_line_q;
    logic [1:0]        full_q;
    logic [1:0]        edge_fifo_q;
    logic              wr_bank_q, rd_bank_q;
    logic              thr_load_q;

    logic [BLK_W-1:0]  nb_m1;
    logic              xfer, emit;
    logic              in_pix_last, in_blk_last, in_line_last;
    logic              out_pix_last, out_blk_last, out_line_last;
    logic              in_blk_done, out_blk_done, in_frame_done;
    logic              in_blk_edge;

    // ------------------------------------------------------------------
    // Datapath strobes and handshakes
    // ------------------------------------------------------------------
    assign nb_m1 = type_q ? WIDE_M1 : NARROW_M1;

    assign in_pix_last   = (in_pix_q == PIX_M1);
    assign in_blk_last   = (in_blk_q == nb_m1);
    assign in_line_last  = (in_line_q == LINES_M1);
    assign out_pix_last  = (out_pix_q == PIX_M1);
    assign out_blk_last  = (out_blk_q == nb_m1);
    assign out_line_last = (out_line_q == LINES_M1);

    // The bank under fill must be empty. When both banks hold completed
    // blocks, input stalls until the replay side frees one.
    assign in_ready   = (state_q == S_RUN) && !full_q[wr_bank_q];
    assign xfer       = in_valid && in_ready;
    assign emit_valid = full_q[rd_bank_q];
    assign emit       = emit_valid && out_ready;

    assign acc_en  = xfer;
    assign acc_clr = xfer && (in_pix_q == '0);
    assign wr_en   = xfer;
    assign wr_addr = in_pix_q;
    assign wr_bank = wr_bank_q;
    assign rd_addr = out_pix_q;
    assign rd_bank = rd_bank_q;

    assign in_blk_done   = xfer && in_pix_last;
    assign in_frame_done = in_blk_done && in_blk_last && in_line_last;
    assign out_blk_done  = emit && out_pix_last;
    assign in_blk_edge   = (in_blk_q == '0) || in_blk_last;

    assign emit_last = emit_valid && out_line_last && out_blk_last && out_pix_last;
    // Blocks retire in the order they were filled. Each bank therefore
    // carries its own edge flag, so this two-entry FIFO is indexed by
    // bank and popped implicitly when rd_bank toggles.
    assign emit_edge = edge_fifo_q[rd_bank_q];
    assign thr_load  = thr_load_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and infers a latch.
        state_d = state_q;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (in_frame_done) state_d = S_DRAIN;
            S_DRAIN: if (emit && emit_last) state_d = S_FLUSH;
            S_FLUSH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, bank flags
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers therefore update together from pre-edge values, whatever
    // order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            // The two edge flags are ordinary flops, not a RAM, so they
            // are reset along with everything else.
            state_q     <= S_IDLE;
            type_q      <= 1'b0;
            in_pix_q    <= '0;
            in_blk_q    <= '0;
            in_line_q   <= '0;
            out_pix_q   <= '0;
            out_blk_q   <= '0;
            out_line_q  <= '0;
            full_q      <= '0;
            edge_fifo_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            thr_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            thr_load_q <= in_blk_done;

            if (state_q == S_IDLE && start) begin
                type_q     <= type_sel;
                in_pix_q   <= '0;
                in_blk_q   <= '0;
                in_line_q  <= '0;
                out_pix_q  <= '0;
                out_blk_q  <= '0;
                out_line_q <= '0;
            end

            if (xfer) begin
                in_pix_q <= in_pix_last ? '0 : in_pix_q + 1'b1;
                if (in_pix_last) begin
                    in_blk_q <= in_blk_last ? '0 : in_blk_q + 1'b1;
                    if (in_blk_last)
                        in_line_q <= in_line_last ? '0 : in_line_q + 1'b1;
                end
            end

            if (emit) begin
                out_pix_q <= out_pix_last ? '0 : out_pix_q + 1'b1;
                if (out_pix_last) begin
                    out_blk_q <= out_blk_last ? '0 : out_blk_q + 1'b1;
                    if (out_blk_last)
                        out_line_q <= out_line_last ? '0 : out_line_q + 1'b1;
                end
            end

            // The fill bank is never full, so set and clear can never
            // target the same bank in one cycle.
            if (in_blk_done) begin
                full_q[wr_bank_q]      <= 1'b1;
                edge_fifo_q[wr_bank_q] <= in_blk_edge;
                wr_bank_q              <= ~wr_bank_q;
            end
            if (out_blk_done) begin
                full_q[rd_bank_q] <= 1'b0;
                rd_bank_q         <= ~rd_bank_q;
            end
        end
    end

endmodule

// File: tb/tb_ate_block_scheduler.sv
module tb_ate_block_scheduler;

    localparam int PIX   = 64;
    localparam int BN    = 6;
    localparam int BW    = 66;
    localparam int LINES = 2;

    logic       clk, rst, start, type_sel, in_valid, out_ready;
    logic       in_ready, acc_clr, acc_en, wr_en, wr_bank, rd_bank;
    logic [5:0] wr_addr, rd_addr;
    logic       thr_load, emit_valid, emit_edge, emit_last, busy, done;

    ate_block_scheduler #(
        .PIX_PER_BLK(PIX), .BLK_NARROW(BN), .BLK_WIDE(BW), .LINES(LINES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .type_sel(type_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
        .acc_clr(acc_clr), .acc_en(acc_en), .wr_en(wr_en),
        .wr_bank(wr_bank), .wr_addr(wr_addr), .rd_bank(rd_bank),
        .rd_addr(rd_addr), .thr_load(thr_load), .emit_valid(emit_valid),
        .emit_edge(emit_edge), .emit_last(emit_last), .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        bit bank;
        int addr;
        bit edge_f;
        bit last;
    } exp_t;

    exp_t sb[$];
    bit   m_active;
    bit   m_type;
    int   m_total, m_acc, m_emit, frames_done;
    bit   prev_thr, prev_last;

    function automatic int nb_of(input bit t);
        return t ? BW : BN;
    endfunction

    initial begin
        m_active = 0; m_acc = 0; m_emit = 0; m_total = 0;
        frames_done = 0; prev_thr = 0; prev_last = 0; m_type = 0;
    end

    // Monitor: samples on the falling edge, where inputs and
    // combinational outputs are stable ahead of the next rising edge.
    always @(negedge clk) begin
        bit   exp_ir, exp_ev, acc, emt, new_thr, new_last;
        int   p, nb, blk;
        exp_t e, got;
        if (rst) begin
            m_active = 0; sb.delete(); m_acc = 0; m_emit = 0;
            prev_thr = 0; prev_last = 0;
        end else begin
            exp_ir = m_active && (m_acc < m_total) && ((m_acc / PIX) - (m_emit / PIX) < 2);
            exp_ev = m_active && ((m_acc / PIX) > (m_emit / PIX));
            check("in_ready", in_ready, exp_ir);
            check("emit_valid", emit_valid, exp_ev);
            check("busy", busy, m_active);
            check("thr_load", thr_load, prev_thr);
            check("done", done, prev_last);

            if (start && !m_active) begin
                m_active = 1; m_type = type_sel;
                m_total  = LINES * nb_of(type_sel) * PIX;
                m_acc = 0; m_emit = 0;
            end

            acc = in_valid && exp_ir;
            emt = out_ready && exp_ev;
            new_thr = 0; new_last = 0;
            p = m_acc;
            check("wr_en", wr_en, acc);
            check("acc_en", acc_en, acc);
            check("acc_clr", acc_clr, acc && (p % PIX == 0));
            if (acc) begin
                nb  = nb_of(m_type);
                blk = (p / PIX) % nb;
                check("wr_addr", wr_addr, p % PIX);
                check("wr_bank", wr_bank, (p / PIX) % 2);
                e.bank   = ((p / PIX) % 2) == 1;
                e.addr   = p % PIX;
                e.edge_f = (blk == 0) || (blk == nb - 1);
                e.last   = (p == m_total - 1);
                sb.push_back(e);
                new_thr = (p % PIX == PIX - 1);
                m_acc++;
            end
            if (emt) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty_on_emit", 1, 0);
                end else begin
                    got = sb.pop_front();
                    check("rd_bank", rd_bank, got.bank);
                    check("rd_addr", rd_addr, got.addr);
                    check("emit_edge", emit_edge, got.edge_f);
                    check("emit_last", emit_last, got.last);
                    new_last = got.last;
                end
                m_emit++;
            end

            if (prev_last) begin
                frames_done++;
                m_active = 0;
            end
            prev_thr  = new_thr;
            prev_last = new_last;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_frame(input bit t);
        @(posedge clk); #1;
        in_valid = 0; start = 1; type_sel = t;
        @(posedge clk); #1;
        start = 0; type_sel = ~t;  // mid-frame type changes must be ignored
    endtask

    task automatic run_to_done(input int vp, input int rp, input int budget,
                               input int mid_start, input int exp_total);
        int f0, cyc;
        f0 = frames_done; cyc = 0;
        while (frames_done == f0 && cyc < budget) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(99) < vp);
            out_ready = ($urandom_range(99) < rp);
            start     = (cyc == mid_start);
            cyc++;
        end
        start = 0; in_valid = 0;
        check("frame_completed", frames_done - f0, 1);
        check("frame_accepts", m_acc, exp_total);
        check("frame_emits", m_emit, exp_total);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_emit_valid"}, emit_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_thr_load"}, thr_load, 0);
        check({tag, "_wr_bank"}, wr_bank, 0);
        check({tag, "_rd_bank"}, rd_bank, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_emit_edge"}, emit_edge, 0);
        check({tag, "_emit_last"}, emit_last, 0);
    endtask

    initial begin
        int cyc, f0;
        rst = 1; start = 0; type_sel = 0; in_valid = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 0;

        // Narrow lines, continuous flow: input never stalls.
        start_frame(0);
        run_to_done(100, 100, 3000, -1, LINES * BN * PIX);

        // Wide lines, continuous flow.
        start_frame(1);
        run_to_done(100, 100, 12000, -1, LINES * BW * PIX);

        // Downstream stalled from the start: exactly two blocks fit.
        start_frame(0);
        in_valid = 1; out_ready = 0;
        cyc = 0;
        while (in_ready !== 1'b0 || cyc == 0) begin
            @(posedge clk); #1; cyc++;
            if (cyc > 400) break;
        end
        check("stall_accepts", m_acc, 2 * PIX);
        repeat (20) @(posedge clk);
        #1;
        check("stall_hold_accepts", m_acc, 2 * PIX);
        out_ready = 1;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("resume_latency", cyc, PIX);
        run_to_done(100, 100, 3000, -1, LINES * BN * PIX);

        // Random handshakes, both widths.
        start_frame(0);
        run_to_done(50, 50, 10000, -1, LINES * BN * PIX);
        start_frame(1);
        run_to_done(70, 70, 40000, -1, LINES * BW * PIX);

        // Reset in the middle of block 2, then a clean frame.
        start_frame(0);
        in_valid = 1; out_ready = 1;
        cyc = 0;
        while (m_acc < 2 * PIX + 10 && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
        end
        check("reached_block2", m_acc >= 2 * PIX + 10, 1);
        rst = 1; in_valid = 0;
        @(posedge clk); #1;
        check_reset_outputs("midframe_reset");
        rst = 0;
        start_frame(0);
        run_to_done(60, 60, 8000, -1, LINES * BN * PIX);

        // Start pulsed during RUN has no effect; exactly one done.
        start_frame(0);
        run_to_done(100, 100, 3000, 100, LINES * BN * PIX);
        f0 = frames_done;
        repeat (200) @(posedge clk);
        #1;
        check("no_extra_done", frames_done - f0, 0);
        check("idle_after_frame", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
